f_fetch_unit: RTL and testbench

- Fetch-stage PC register and instruction-fetch sequencer.
- It is the consumer end of the decode-stage next-PC path. It takes the resolved branch/jump target from D, owns the architectural fetch PC, and issues request/grant/response transactions to instruction memory.
- It loads the F/D pipeline register (D_instr, D_PC, D_valid) and honours hazard-unit stalls and MIPS single delay-slot semantics.

---
 rtl/f_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_f_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_unit.sv
// Fetch-stage PC register and instruction-fetch sequencer.
// Owns the architectural fetch PC, runs a single-outstanding req/gnt/rvalid
// handshake to instruction memory, and loads the F/D pipeline register with
// MIPS single delay-slot branch semantics and hazard-unit stall support.
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] D_instr,
    output logic [31:0] D_PC,
    output logic        D_valid
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic        r_im_req;
    logic [31:0] r_hold_buf;
    logic [31:0] r_f_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic [31:0] r_d_instr;
    logic [31:0] r_d_pc;
    logic        r_d_valid;

    logic        w_deliver;
    logic [31:0] w_word;
    logic [31:0] w_br_aligned;
    logic [31:0] w_next_pc;

    // Deliver decision, source word selection and next-PC priority
    always_comb begin
        w_deliver    = ~stall & (((r_state == S_WAIT) & im_rvalid) | (r_state == S_HOLD));
        w_word       = (r_state == S_HOLD) ? r_hold_buf : im_rdata;
        w_br_aligned = br_target & ~32'd3;
        if (br_valid) begin
            w_next_pc = w_br_aligned;
        end else if (r_pend_valid) begin
            w_next_pc = r_pend_target;
        end else begin
            w_next_pc = r_f_pc + 32'd4;
        end
    end

    // Memory handshake FSM; im_req is raised only once out of reset so no
    // request is visible while reset is asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_im_req   <= 1'b0;
            r_hold_buf <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (r_im_req && im_gnt) begin
                        r_state  <= S_WAIT;
                        r_im_req <= 1'b0;
                    end else begin
                        r_im_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (im_rvalid) begin
                        if (!stall) begin
                            r_state  <= S_REQ;
                            r_im_req <= 1'b1;
                        end else begin
                            r_state    <= S_HOLD;
                            r_hold_buf <= im_rdata;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_state  <= S_REQ;
                        r_im_req <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_REQ;
                    r_im_req <= 1'b0;
                end
            endcase
        end
    end

    // Fetch PC and pending (delay-slot) branch target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f_pc        <= {RESET_PC[31:2], 2'b00};
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (w_deliver) begin
            r_f_pc <= w_next_pc;
            if (!br_valid && r_pend_valid) begin
                r_pend_valid <= 1'b0;
            end
        end else if (br_valid) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_br_aligned;
        end
    end

    // F/D pipeline register: load on deliver, hold on stall, else bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_instr <= '0;
            r_d_pc    <= '0;
            r_d_valid <= 1'b0;
        end else if (w_deliver) begin
            r_d_instr <= w_word;
            r_d_pc    <= r_f_pc;
            r_d_valid <= 1'b1;
        end else if (!stall) begin
            r_d_instr <= '0;
            r_d_pc    <= r_f_pc;
            r_d_valid <= 1'b0;
        end
    end

    assign im_req  = r_im_req;
    assign im_addr = {r_f_pc[31:2], 2'b00};
    assign F_PC    = r_f_pc;
    assign D_instr = r_d_instr;
    assign D_PC    = r_d_pc;
    assign D_valid = r_d_valid;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Randomized scoreboard bench for f_fetch_unit: a memory responder with
// random grant/response latency, random stalls and branches, and a
// program-order reference model of the fetch PC stream.
module tb_f_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] F_PC;
    logic [31:0] D_instr;
    logic [31:0] D_PC;
    logic        D_valid;

    f_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .br_valid (br_valid),
        .br_target(br_target),
        .im_req   (im_req),
        .im_addr  (im_addr),
        .im_gnt   (im_gnt),
        .im_rvalid(im_rvalid),
        .im_rdata (im_rdata),
        .F_PC     (F_PC),
        .D_instr  (D_instr),
        .D_PC     (D_PC),
        .D_valid  (D_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] fpc;
    } dexp_t;

    dexp_t       q_del[$];
    logic [31:0] q_fetch[$];

    int unsigned total = 0;
    int unsigned bad   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model + memory responder ----------------
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_t;
    int unsigned ph;
    int unsigned dly;
    logic [31:0] held;
    logic        first_word;

    function automatic logic [31:0] align(logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        m_pc     = RPC;
        m_pend   = 1'b0;
        m_pend_t = '0;
        ph       = 0;
        dly      = 0;
        q_del.delete();
        q_fetch.delete();
        q_fetch.push_back(RPC);
    endtask

    // Drive one cycle of inputs (called 2 time units after a rising edge)
    task automatic step();
        logic        dl;
        logic [31:0] w;
        logic [31:0] r;
        logic [31:0] nxt;
        dexp_t       e;
        dl        = 1'b0;
        w         = '0;
        stall     = ($urandom % 100) < 30;
        br_valid  = ($urandom % 100) < 12;
        r         = $urandom;
        br_target = (($urandom % 8) == 0) ? 32'hFFFF_FFFD : (r & 32'h0000_FFFF);
        im_gnt    = 1'b0;
        im_rvalid = 1'b0;
        im_rdata  = $urandom;
        case (ph)
            0: begin
                im_rvalid = ($urandom % 100) < 20;
                if (im_req && (($urandom % 100) < 70)) begin
                    im_gnt = 1'b1;
                    ph     = 1;
                    dly    = $urandom % 4;
                end
            end
            1: begin
                if (dly == 0) begin
                    im_rvalid = 1'b1;
                    if (first_word) begin
                        im_rdata   = 32'h3C01_1234;
                        first_word = 1'b0;
                    end
                    w = im_rdata;
                    if (!stall) begin
                        dl = 1'b1;
                        ph = 0;
                    end else begin
                        held = w;
                        ph   = 2;
                    end
                end else begin
                    dly--;
                end
            end
            default: begin
                im_rvalid = ($urandom % 100) < 30;
                if (!stall) begin
                    dl = 1'b1;
                    w  = held;
                    ph = 0;
                end
            end
        endcase
        if (dl) begin
            if (br_valid) begin
                nxt = align(br_target);
            end else if (m_pend) begin
                nxt    = m_pend_t;
                m_pend = 1'b0;
            end else begin
                nxt = m_pc + 32'd4;
            end
            e.instr = w;
            e.pc    = m_pc;
            e.fpc   = nxt;
            q_del.push_back(e);
            q_fetch.push_back(nxt);
            m_pc = nxt;
        end else if (br_valid) begin
            m_pend   = 1'b1;
            m_pend_t = align(br_target);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_target = '0;
        im_gnt    = 1'b0;
        im_rvalid = 1'b1;
        im_rdata  = 32'hDEAD_BEEF;
    endtask

    // ---------------- monitor ----------------
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        exp_dv = 1'b0;
    logic [31:0] exp_di = '0;
    logic [31:0] exp_dp = '0;
    logic [31:0] exp_fpc = RPC;

    // Compare DUT outputs just after every rising edge against the queues
    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_req = 1'b0;
            exp_dv   = 1'b0;
            exp_di   = '0;
            exp_dp   = '0;
            exp_fpc  = RPC;
        end else begin
            if (prev_req && im_gnt) begin
                if (q_fetch.size() == 0) begin
                    check("fetch_unexpected", 32'd1, 32'd0);
                end else begin
                    check("im_addr", prev_addr, q_fetch.pop_front());
                end
                check("im_req_low_in_wait", {31'd0, im_req}, 32'd0);
            end
            if (stall) begin
                check("hold_D_valid", {31'd0, D_valid}, {31'd0, exp_dv});
                check("hold_D_instr", D_instr, exp_di);
                check("hold_D_PC", D_PC, exp_dp);
            end else if (D_valid) begin
                if (q_del.size() == 0) begin
                    check("deliver_unexpected", 32'd1, 32'd0);
                end else begin
                    dexp_t e;
                    e = q_del.pop_front();
                    check("D_instr", D_instr, e.instr);
                    check("D_PC", D_PC, e.pc);
                    check("F_PC_after_deliver", F_PC, e.fpc);
                    exp_dv  = 1'b1;
                    exp_di  = e.instr;
                    exp_dp  = e.pc;
                    exp_fpc = e.fpc;
                end
            end else begin
                check("bubble_D_instr", D_instr, 32'd0);
                check("bubble_D_PC", D_PC, exp_fpc);
                check("bubble_F_PC", F_PC, exp_fpc);
                exp_dv = 1'b0;
                exp_di = '0;
                exp_dp = exp_fpc;
            end
            prev_req  = im_req;
            prev_addr = im_addr;
        end
    end

    // ---------------- main stimulus ----------------
    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        br_valid   = 1'b0;
        br_target  = '0;
        im_gnt     = 1'b0;
        im_rvalid  = 1'b0;
        im_rdata   = '0;
        held       = '0;
        first_word = 1'b1;
        model_reset();
        #3;
        check("rst_F_PC", F_PC, RPC);
        check("rst_im_req", {31'd0, im_req}, 32'd0);
        check("rst_D_valid", {31'd0, D_valid}, 32'd0);
        check("rst_D_instr", D_instr, 32'd0);
        check("rst_D_PC", D_PC, 32'd0);
        @(posedge clk);
        release_reset();

        for (int unsigned c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            step();
        end

        // Assert reset while a fetch is outstanding
        begin
            int unsigned bound;
            bound = 0;
            while (ph != 1 && bound < 200) begin
                @(posedge clk);
                #2;
                step();
                bound++;
            end
            if (ph != 1) check("reach_wait_timeout", 32'd1, 32'd0);
        end
        @(posedge clk);
        #2;
        reset     = 1'b1;
        im_gnt    = 1'b0;
        im_rvalid = 1'b0;
        #1;
        check("midrst_D_valid", {31'd0, D_valid}, 32'd0);
        check("midrst_F_PC", F_PC, RPC);
        check("midrst_im_req", {31'd0, im_req}, 32'd0);
        model_reset();
        release_reset();

        for (int unsigned c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            step();
        end

        @(posedge clk);
        #2;
        stall     = 1'b1;
        im_gnt    = 1'b0;
        im_rvalid = 1'b0;
        br_valid  = 1'b0;
        @(posedge clk);
        #3;
        check("queue_drained", q_del.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
